// File: rtl/seg_scan_pkg.sv
// Shared constants for the multiplexed seven-segment scan driver.
// Optional decimal-point support is enabled with SEG_SCAN_DP_EN.
package seg_scan_pkg;

    localparam int IDX_W = 3;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [7:0] AN_ALL_OFF = 8'hFF;

    // Active-high segments g..a; element 15 is listed first.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg_hex_lut.sv
// Hex nibble to active-high seven-segment pattern (g..a).
// Purely combinational.
module seg_hex_lut
    import seg_scan_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SEG_LUT[nib];

endmodule

// File: rtl/seg_scan_driver.sv
// Double-buffered 8-digit common-anode seven-segment scan driver.
// Define SEG_SCAN_DP_EN to add per-digit decimal points (dp / dp_n).
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int CLK_DIV    = 50000,
    parameter int NUM_DIGITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data,
    input  logic [7:0]  dig_en,
    input  logic        load,
`ifdef SEG_SCAN_DP_EN
    input  logic [7:0]  dp,
`endif
    output logic [7:0]  an_n,
    output logic [6:0]  seg_n,
`ifdef SEG_SCAN_DP_EN
    output logic        dp_n,
`endif
    output logic        frame_done
);

    localparam int PS_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PS_W-1:0]  PS_MAX  = PS_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    logic [PS_W-1:0]  ps;
    logic [IDX_W-1:0] idx;
    logic             tick;
    logic             boundary;

    logic [31:0] act_data;
    logic [7:0]  act_mask;
    logic [31:0] pend_data;
    logic [7:0]  pend_mask;
    logic        pend;

    logic [3:0] cur_nib;
    logic       cur_en;
    logic [6:0] cur_seg;

    assign tick     = (ps == PS_MAX);
    assign boundary = tick && (idx == IDX_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps  <= '0;
            idx <= '0;
        end else if (tick) begin
            ps  <= '0;
            idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end else begin
            ps  <= ps + 1'b1;
        end
    end

    // A load on the boundary bypasses the pending slot entirely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_data  <= '0;
            act_mask  <= '0;
            pend_data <= '0;
            pend_mask <= '0;
            pend      <= 1'b0;
        end else if (boundary && load) begin
            act_data  <= data;
            act_mask  <= dig_en;
            pend      <= 1'b0;
        end else if (boundary && pend) begin
            act_data  <= pend_data;
            act_mask  <= pend_mask;
            pend      <= 1'b0;
        end else if (load) begin
            pend_data <= data;
            pend_mask <= dig_en;
            pend      <= 1'b1;
        end
    end

    assign cur_nib = act_data[{idx, 2'b00} +: 4];
    assign cur_en  = act_mask[idx];

    seg_hex_lut u_lut (
        .nib (cur_nib),
        .seg (cur_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_n       <= AN_ALL_OFF;
            seg_n      <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            an_n       <= cur_en ? ~(8'b1 << idx) : AN_ALL_OFF;
            seg_n      <= cur_en ? ~cur_seg : SEG_BLANK;
            frame_done <= boundary;
        end
    end

`ifdef SEG_SCAN_DP_EN
    logic [7:0] act_dp;
    logic [7:0] pend_dp;

    // Mirrors the data/mask buffering so dp always matches its digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_dp  <= '0;
            pend_dp <= '0;
        end else if (boundary && load) begin
            act_dp  <= dp;
        end else if (boundary && pend) begin
            act_dp  <= pend_dp;
        end else if (load) begin
            pend_dp <= dp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_n <= 1'b1;
        end else begin
            dp_n <= ~(act_dp[idx] & cur_en);
        end
    end
`endif

endmodule
